// File: rtl/accumulator_skewed.sv
// Skewed ping-pong accumulator for the systolic-array output wavefront.
// Lane k acts on the lane-0 request from k cycles earlier; reads drain the half not being written.
module accumulator_skewed #(
    parameter int LANES = 32,
    parameter int IN_W  = 32,
    parameter int ACC_W = 40,
    parameter int DEPTH = 512,
    parameter bit SAT   = 1'b1,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        wr_en_i,
    input  logic                        wr_acc_i,
    input  logic [AW-1:0]               wr_addr_i,
    input  logic [LANES-1:0]            wr_mask_i,
    input  logic [LANES-1:0][IN_W-1:0]  data_i,
    input  logic                        rd_en_i,
    input  logic [AW-1:0]               rd_addr_i,
    input  logic [LANES-1:0]            rd_mask_i,
    input  logic                        swap_i,
    input  logic                        clr_ovf_i,
    output logic [LANES-1:0][ACC_W-1:0] data_o,
    output logic [LANES-1:0]            valid_o,
    output logic                        bank_sel_o,
    output logic                        overflow_o
);

    typedef struct packed {
        logic             en;
        logic             acc;
        logic [AW-1:0]    addr;
        logic [LANES-1:0] mask;
        logic             half;
    } wr_req_t;

    typedef struct packed {
        logic             en;
        logic [AW-1:0]    addr;
        logic [LANES-1:0] mask;
        logic             half;
    } rd_req_t;

    wr_req_t wr_live;
    rd_req_t rd_live;
    wr_req_t wr_skew_q [LANES-1];
    wr_req_t wr_skew_d [LANES-1];
    rd_req_t rd_skew_q [LANES-1];
    rd_req_t rd_skew_d [LANES-1];

    logic                        bank_sel_q, bank_sel_d;
    logic                        overflow_q, overflow_d;
    logic [LANES-1:0][ACC_W-1:0] data_q, data_d;
    logic [LANES-1:0]            valid_q, valid_d;
    logic [LANES-1:0]            ovf_lane;

    // The half bit travels with each request so a wavefront never splits across a swap.
    assign wr_live = '{en: wr_en_i, acc: wr_acc_i, addr: wr_addr_i, mask: wr_mask_i, half: bank_sel_q};
    assign rd_live = '{en: rd_en_i, addr: rd_addr_i, mask: rd_mask_i, half: ~bank_sel_q};

    always_comb begin
        wr_skew_d[0] = wr_live;
        rd_skew_d[0] = rd_live;
        for (int i = 1; i < LANES-1; i++) begin
            wr_skew_d[i] = wr_skew_q[i-1];
            rd_skew_d[i] = rd_skew_q[i-1];
        end
        bank_sel_d = bank_sel_q ^ swap_i;
        overflow_d = (overflow_q & ~clr_ovf_i) | (|ovf_lane);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < LANES-1; i++) begin
                wr_skew_q[i] <= '0;
                rd_skew_q[i] <= '0;
            end
            bank_sel_q <= 1'b0;
            overflow_q <= 1'b0;
            data_q     <= '0;
            valid_q    <= '0;
        end else begin
            wr_skew_q  <= wr_skew_d;
            rd_skew_q  <= rd_skew_d;
            bank_sel_q <= bank_sel_d;
            overflow_q <= overflow_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [ACC_W-1:0] mem [2*DEPTH];
        logic             we, wacc, re, ovf;
        logic [AW:0]      waddr, raddr;
        logic [ACC_W-1:0] old_val, new_val;
        logic [ACC_W:0]   sum;

        if (k == 0) begin : g_head
            assign we    = wr_live.en & wr_live.mask[0];
            assign wacc  = wr_live.acc;
            assign waddr = {wr_live.half, wr_live.addr};
            assign re    = rd_live.en & rd_live.mask[0];
            assign raddr = {rd_live.half, rd_live.addr};
        end else begin : g_tail
            assign we    = wr_skew_q[k-1].en & wr_skew_q[k-1].mask[k];
            assign wacc  = wr_skew_q[k-1].acc;
            assign waddr = {wr_skew_q[k-1].half, wr_skew_q[k-1].addr};
            assign re    = rd_skew_q[k-1].en & rd_skew_q[k-1].mask[k];
            assign raddr = {rd_skew_q[k-1].half, rd_skew_q[k-1].addr};
        end

        assign old_val = mem[waddr];

        // One guard bit above ACC_W exposes signed overflow as a sign mismatch.
        always_comb begin
            sum = {{(ACC_W+1-IN_W){data_i[k][IN_W-1]}}, data_i[k]};
            if (wacc) begin
                sum = sum + {old_val[ACC_W-1], old_val};
            end
            ovf     = sum[ACC_W] ^ sum[ACC_W-1];
            new_val = sum[ACC_W-1:0];
            if (SAT && ovf) begin
                new_val = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
            end
        end

        assign ovf_lane[k] = we & ovf;

        always_ff @(posedge clk_i) begin
            if (we) begin
                mem[waddr] <= new_val;
            end
        end

        assign data_d[k]  = re ? mem[raddr] : '0;
        assign valid_d[k] = re;
    end

    assign data_o     = data_q;
    assign valid_o    = valid_q;
    assign bank_sel_o = bank_sel_q;
    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_accumulator_skewed.sv
// Bench for accumulator_skewed: SAT=1 and SAT=0 instances share stimulus; a queue-based
// per-lane event model predicts every output each cycle, plus a table of hand-computed readbacks.
module tb_accumulator_skewed;
    localparam int LANES = 4;
    localparam int IN_W  = 8;
    localparam int ACC_W = 10;
    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int MAXV  = 511;
    localparam int MINV  = -512;

    logic clk = 1'b0;
    logic rst_n;
    logic wr_en, wr_acc, rd_en, swap, clr;
    logic [AW-1:0] wr_addr, rd_addr;
    logic [LANES-1:0] wr_mask, rd_mask;
    logic [LANES-1:0][IN_W-1:0] data_in;
    logic [LANES-1:0][ACC_W-1:0] data_s, data_w;
    logic [LANES-1:0] valid_s, valid_w;
    logic bank_s, bank_w, ovf_s, ovf_w;

    always #5 clk = ~clk;

    accumulator_skewed #(.LANES(LANES), .IN_W(IN_W), .ACC_W(ACC_W), .DEPTH(DEPTH), .SAT(1'b1)) u_sat (
        .clk_i(clk), .rst_i(rst_n), .wr_en_i(wr_en), .wr_acc_i(wr_acc), .wr_addr_i(wr_addr),
        .wr_mask_i(wr_mask), .data_i(data_in), .rd_en_i(rd_en), .rd_addr_i(rd_addr),
        .rd_mask_i(rd_mask), .swap_i(swap), .clr_ovf_i(clr), .data_o(data_s), .valid_o(valid_s),
        .bank_sel_o(bank_s), .overflow_o(ovf_s));

    accumulator_skewed #(.LANES(LANES), .IN_W(IN_W), .ACC_W(ACC_W), .DEPTH(DEPTH), .SAT(1'b0)) u_wrap (
        .clk_i(clk), .rst_i(rst_n), .wr_en_i(wr_en), .wr_acc_i(wr_acc), .wr_addr_i(wr_addr),
        .wr_mask_i(wr_mask), .data_i(data_in), .rd_en_i(rd_en), .rd_addr_i(rd_addr),
        .rd_mask_i(rd_mask), .swap_i(swap), .clr_ovf_i(clr), .data_o(data_w), .valid_o(valid_w),
        .bank_sel_o(bank_w), .overflow_o(ovf_w));

    typedef struct { int due; int lane; bit acc; int addr; int half; } wop_t;
    typedef struct { int due; int lane; int addr; int half; } rop_t;
    typedef struct { int due; int lane; int val; } dop_t;
    typedef struct {
        int addr; int v0; bit acc1; int v1; int n1;
        logic [LANES-1:0] mask1; logic [LANES-1:0] rmask;
        int e0, e1, e2, e3; bit bank;
    } vec_t;

    wop_t wq[$];
    rop_t rq[$];
    dop_t dq[$];
    int   mem_m [2][LANES][2][DEPTH];
    int   bank_m;
    bit   ovf_m [2];
    logic [LANES-1:0] exp_v;
    int   exp_d [2][LANES];
    int   got_d [2][LANES];
    bit   got_v [2][LANES];
    int   cyc, n_checks, n_fail;
    vec_t tbl [7];

    task automatic check(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int dut_data(int s, int k);
        return (s == 0) ? int'($signed(data_s[k])) : int'($signed(data_w[k]));
    endfunction

    function automatic int row_exp(vec_t r, int k);
        case (k)
            0: return r.e0;
            1: return r.e1;
            2: return r.e2;
            default: return r.e3;
        endcase
    endfunction

    task automatic idle();
        wr_en = 1'b0; wr_acc = 1'($urandom); wr_addr = AW'($urandom); wr_mask = LANES'($urandom);
        rd_en = 1'b0; rd_addr = AW'($urandom); rd_mask = LANES'($urandom);
        swap = 1'b0; clr = 1'b0;
    endtask

    task automatic set_wr(bit acc, int addr, logic [LANES-1:0] mask, int val);
        wr_en = 1'b1; wr_acc = acc; wr_addr = AW'(addr); wr_mask = mask;
        for (int k = 0; k < LANES; k++) dq.push_back('{cyc + k, k, val});
    endtask

    task automatic check_outputs();
        check("sat.valid", int'(valid_s), int'(exp_v));
        check("wrap.valid", int'(valid_w), int'(exp_v));
        check("sat.bank", int'(bank_s), bank_m);
        check("wrap.bank", int'(bank_w), bank_m);
        check("sat.ovf", int'(ovf_s), int'(ovf_m[0]));
        check("wrap.ovf", int'(ovf_w), int'(ovf_m[1]));
        for (int k = 0; k < LANES; k++) begin
            check($sformatf("sat.data[%0d]", k), dut_data(0, k), exp_d[0][k]);
            check($sformatf("wrap.data[%0d]", k), dut_data(1, k), exp_d[1][k]);
        end
    endtask

    // One clock: drive lane data, predict the edge with per-lane due-cycle events, then compare.
    task automatic step();
        dop_t dk[$];
        wop_t wk[$];
        rop_t rk[$];
        bit   nov [2];
        int   v;
        for (int k = 0; k < LANES; k++) data_in[k] = IN_W'($urandom);
        foreach (dq[i]) begin
            if (dq[i].due == cyc) data_in[dq[i].lane] = IN_W'(dq[i].val);
            else dk.push_back(dq[i]);
        end
        dq = dk;
        if (wr_en) for (int k = 0; k < LANES; k++)
            if (wr_mask[k]) wq.push_back('{cyc + k, k, wr_acc, int'(wr_addr), bank_m});
        if (rd_en) for (int k = 0; k < LANES; k++)
            if (rd_mask[k]) rq.push_back('{cyc + k, k, int'(rd_addr), 1 - bank_m});
        exp_v = '0;
        for (int s = 0; s < 2; s++) for (int k = 0; k < LANES; k++) exp_d[s][k] = 0;
        foreach (rq[i]) begin
            if (rq[i].due == cyc) begin
                exp_v[rq[i].lane] = 1'b1;
                for (int s = 0; s < 2; s++) exp_d[s][rq[i].lane] = mem_m[s][rq[i].lane][rq[i].half][rq[i].addr];
            end else rk.push_back(rq[i]);
        end
        rq = rk;
        nov[0] = 1'b0; nov[1] = 1'b0;
        foreach (wq[i]) begin
            if (wq[i].due == cyc) begin
                for (int s = 0; s < 2; s++) begin
                    v = int'($signed(data_in[wq[i].lane]));
                    if (wq[i].acc) v = v + mem_m[s][wq[i].lane][wq[i].half][wq[i].addr];
                    if (v > MAXV || v < MINV) begin
                        nov[s] = 1'b1;
                        if (s == 0) v = (v > MAXV) ? MAXV : MINV;
                        else v = ((v + 512) & 1023) - 512;
                    end
                    mem_m[s][wq[i].lane][wq[i].half][wq[i].addr] = v;
                end
            end else wk.push_back(wq[i]);
        end
        wq = wk;
        for (int s = 0; s < 2; s++) ovf_m[s] = (ovf_m[s] && !clr) || nov[s];
        if (swap) bank_m = 1 - bank_m;
        @(posedge clk);
        #1;
        cyc++;
        check_outputs();
        idle();
    endtask

    task automatic read_wave(int addr, logic [LANES-1:0] mask);
        rd_en = 1'b1; rd_addr = AW'(addr); rd_mask = mask;
        for (int j = 0; j < LANES; j++) begin
            step();
            got_v[0][j] = valid_s[j];
            got_v[1][j] = valid_w[j];
            got_d[0][j] = dut_data(0, j);
            got_d[1][j] = dut_data(1, j);
        end
    endtask

    task automatic run_row(int idx, vec_t r);
        set_wr(1'b0, r.addr, '1, r.v0);
        step();
        for (int i = 0; i < r.n1; i++) begin
            set_wr(r.acc1, r.addr, r.mask1, r.v1);
            step();
        end
        repeat (LANES) step();
        swap = 1'b1;
        step();
        check($sformatf("row%0d.bank", idx), int'(bank_s), int'(r.bank));
        read_wave(r.addr, r.rmask);
        for (int s = 0; s < 2; s++) begin
            for (int k = 0; k < LANES; k++) begin
                check($sformatf("row%0d.inst%0d.valid[%0d]", idx, s, k), int'(got_v[s][k]), int'(r.rmask[k]));
                if (r.rmask[k]) check($sformatf("row%0d.inst%0d.data[%0d]", idx, s, k), got_d[s][k], row_exp(r, k));
            end
        end
    endtask

    initial begin
        n_checks = 0; n_fail = 0; cyc = 0; bank_m = 0;
        ovf_m[0] = 1'b0; ovf_m[1] = 1'b0;
        for (int s = 0; s < 2; s++) for (int k = 0; k < LANES; k++)
            for (int h = 0; h < 2; h++) for (int a = 0; a < DEPTH; a++) mem_m[s][k][h][a] = 0;
        tbl[0] = '{3, 5, 1'b0, 0, 0, 4'hF, 4'hF, 5, 5, 5, 5, 1'b1};
        tbl[1] = '{2, 100, 1'b1, 27, 2, 4'hF, 4'hF, 154, 154, 154, 154, 1'b0};
        tbl[2] = '{6, 1, 1'b0, 9, 1, 4'b0101, 4'hF, 9, 1, 9, 1, 1'b1};
        tbl[3] = '{6, 1, 1'b0, 9, 1, 4'b0101, 4'b0010, 0, 1, 0, 0, 1'b0};
        tbl[4] = '{5, -20, 1'b1, -100, 1, 4'b1010, 4'hF, -20, -120, -20, -120, 1'b1};
        tbl[5] = '{7, 127, 1'b1, 127, 3, 4'hF, 4'hF, 508, 508, 508, 508, 1'b0};
        tbl[6] = '{0, -128, 1'b1, -128, 3, 4'hF, 4'hF, -512, -512, -512, -512, 1'b1};

        rst_n = 1'b0;
        idle();
        data_in = '0;
        #12;
        check("rst.sat.valid", int'(valid_s), 0);
        check("rst.wrap.valid", int'(valid_w), 0);
        check("rst.sat.data", int'(data_s != '0), 0);
        check("rst.wrap.data", int'(data_w != '0), 0);
        check("rst.sat.bank", int'(bank_s), 0);
        check("rst.wrap.bank", int'(bank_w), 0);
        check("rst.sat.ovf", int'(ovf_s), 0);
        check("rst.wrap.ovf", int'(ovf_w), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Give every entry a defined value so later accumulates are predictable.
        for (int h = 0; h < 2; h++) begin
            for (int a = 0; a < DEPTH; a++) begin
                set_wr(1'b0, a, '1, 0);
                step();
            end
            swap = 1'b1;
            step();
        end
        repeat (LANES) step();

        for (int i = 0; i < 7; i++) run_row(i, tbl[i]);

        // Saturation versus wrap at the positive limit, then sticky flag and clear.
        set_wr(1'b0, 1, '1, 127);
        step();
        repeat (3) begin
            set_wr(1'b1, 1, '1, 127);
            step();
        end
        set_wr(1'b1, 1, '1, 3);
        step();
        repeat (LANES) step();
        check("ovf.before.sat", int'(ovf_s), 0);
        check("ovf.before.wrap", int'(ovf_w), 0);
        set_wr(1'b1, 1, '1, 127);
        step();
        repeat (LANES) step();
        check("ovf.set.sat", int'(ovf_s), 1);
        check("ovf.set.wrap", int'(ovf_w), 1);
        repeat (3) step();
        check("ovf.held.sat", int'(ovf_s), 1);
        check("ovf.held.wrap", int'(ovf_w), 1);
        clr = 1'b1;
        step();
        check("ovf.clr.sat", int'(ovf_s), 0);
        check("ovf.clr.wrap", int'(ovf_w), 0);
        swap = 1'b1;
        step();
        read_wave(1, '1);
        for (int k = 0; k < LANES; k++) begin
            check($sformatf("sat.clamp[%0d]", k), got_d[0][k], 511);
            check($sformatf("wrap.value[%0d]", k), got_d[1][k], -386);
        end

        // Swap issued alongside a lane-0 write: whole wavefront stays in the old half.
        set_wr(1'b0, 0, '1, 13);
        step();
        repeat (LANES) step();
        swap = 1'b1;
        step();
        set_wr(1'b0, 0, '1, 77);
        step();
        repeat (LANES) step();
        swap = 1'b1;
        step();
        set_wr(1'b0, 0, '1, 42);
        swap = 1'b1;
        step();
        repeat (LANES) step();
        read_wave(0, '1);
        for (int k = 0; k < LANES; k++) check($sformatf("swap.old[%0d]", k), got_d[0][k], 42);
        swap = 1'b1;
        step();
        read_wave(0, '1);
        for (int k = 0; k < LANES; k++) check($sformatf("swap.new[%0d]", k), got_d[1][k], 77);

        // Reset landing one cycle into a wavefront.
        if (bank_m == 0) begin
            swap = 1'b1;
            step();
        end
        set_wr(1'b0, 4, '1, 11);
        step();
        repeat (LANES) step();
        set_wr(1'b0, 4, '1, 33);
        step();
        rst_n = 1'b0;
        #1;
        check("midrst.sat.valid", int'(valid_s), 0);
        check("midrst.wrap.valid", int'(valid_w), 0);
        check("midrst.sat.bank", int'(bank_s), 0);
        check("midrst.wrap.bank", int'(bank_w), 0);
        check("midrst.sat.ovf", int'(ovf_s), 0);
        wq.delete(); rq.delete(); dq.delete();
        bank_m = 0;
        ovf_m[0] = 1'b0; ovf_m[1] = 1'b0;
        @(posedge clk);
        #1;
        cyc++;
        rst_n = 1'b1;
        read_wave(4, '1);
        for (int s = 0; s < 2; s++) begin
            check($sformatf("midrst.inst%0d.lane0", s), got_d[s][0], 33);
            check($sformatf("midrst.inst%0d.lane2", s), got_d[s][2], 11);
            check($sformatf("midrst.inst%0d.lane3", s), got_d[s][3], 11);
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            wr_en = 1'($urandom);
            rd_en = 1'($urandom);
            swap = ($urandom_range(0, 7) == 0);
            clr = ($urandom_range(0, 5) == 0);
            step();
        end
        repeat (LANES + 1) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
